// File: rtl/udp_demux_if.sv
// UDP frame bus for udp_demux: one header + AXI-stream payload input and
// M_COUNT replicated output lanes with one-hot valids.
interface udp_demux_if #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  localparam int HDR_WIDTH = 336;

  // input side
  logic                            s_udp_hdr_valid;
  logic                            s_udp_hdr_ready;
  logic [HDR_WIDTH-1:0]            s_udp_hdr;
  logic [DATA_WIDTH-1:0]           s_udp_payload_axis_tdata;
  logic [KEEP_WIDTH-1:0]           s_udp_payload_axis_tkeep;
  logic                            s_udp_payload_axis_tvalid;
  logic                            s_udp_payload_axis_tready;
  logic                            s_udp_payload_axis_tlast;
  logic [ID_WIDTH-1:0]             s_udp_payload_axis_tid;
  logic [DEST_WIDTH-1:0]           s_udp_payload_axis_tdest;
  logic [USER_WIDTH-1:0]           s_udp_payload_axis_tuser;

  // output side
  logic [M_COUNT-1:0]              m_udp_hdr_valid;
  logic [M_COUNT-1:0]              m_udp_hdr_ready;
  logic [M_COUNT*HDR_WIDTH-1:0]    m_udp_hdr;
  logic [M_COUNT*DATA_WIDTH-1:0]   m_udp_payload_axis_tdata;
  logic [M_COUNT*KEEP_WIDTH-1:0]   m_udp_payload_axis_tkeep;
  logic [M_COUNT-1:0]              m_udp_payload_axis_tvalid;
  logic [M_COUNT-1:0]              m_udp_payload_axis_tready;
  logic [M_COUNT-1:0]              m_udp_payload_axis_tlast;
  logic [M_COUNT*ID_WIDTH-1:0]     m_udp_payload_axis_tid;
  logic [M_COUNT*DEST_WIDTH-1:0]   m_udp_payload_axis_tdest;
  logic [M_COUNT*USER_WIDTH-1:0]   m_udp_payload_axis_tuser;

  // demux view
  modport slave (
    input  s_udp_hdr_valid, s_udp_hdr,
    input  s_udp_payload_axis_tdata, s_udp_payload_axis_tkeep, s_udp_payload_axis_tvalid,
    input  s_udp_payload_axis_tlast, s_udp_payload_axis_tid, s_udp_payload_axis_tdest,
    input  s_udp_payload_axis_tuser,
    output s_udp_hdr_ready, s_udp_payload_axis_tready,
    output m_udp_hdr_valid, m_udp_hdr,
    output m_udp_payload_axis_tdata, m_udp_payload_axis_tkeep, m_udp_payload_axis_tvalid,
    output m_udp_payload_axis_tlast, m_udp_payload_axis_tid, m_udp_payload_axis_tdest,
    output m_udp_payload_axis_tuser,
    input  m_udp_hdr_ready, m_udp_payload_axis_tready
  );

  // environment view (source of frames, sink of lanes)
  modport master (
    output s_udp_hdr_valid, s_udp_hdr,
    output s_udp_payload_axis_tdata, s_udp_payload_axis_tkeep, s_udp_payload_axis_tvalid,
    output s_udp_payload_axis_tlast, s_udp_payload_axis_tid, s_udp_payload_axis_tdest,
    output s_udp_payload_axis_tuser,
    input  s_udp_hdr_ready, s_udp_payload_axis_tready,
    input  m_udp_hdr_valid, m_udp_hdr,
    input  m_udp_payload_axis_tdata, m_udp_payload_axis_tkeep, m_udp_payload_axis_tvalid,
    input  m_udp_payload_axis_tlast, m_udp_payload_axis_tid, m_udp_payload_axis_tdest,
    input  m_udp_payload_axis_tuser,
    output m_udp_hdr_ready, m_udp_payload_axis_tready
  );
endinterface

// File: rtl/udp_demux.sv
// UDP frame demultiplexer: routes each header+payload frame to the output
// lane picked by `select` at header accept, or discards it when dropped.
// Payload goes through an output register plus skid register so input
// tready can be registered without losing throughput.
module udp_demux #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1,
  parameter int SEL_WIDTH   = $clog2(M_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  udp_demux_if.slave           bus,
  input  logic                 enable,
  input  logic                 drop,
  input  logic [SEL_WIDTH-1:0] select
);
  localparam int HDR_WIDTH = 336;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                 r_state, w_state_next;
  logic                   r_drop, w_drop_next;
  logic [SEL_WIDTH-1:0]   r_sel, w_sel_next;
  logic                   r_run;
  logic [M_COUNT-1:0]     r_hdr_valid, w_hdr_valid_next;
  logic [HDR_WIDTH-1:0]   r_hdr;
  logic                   w_hdr_ready, w_hdr_accept, w_hdr_load, w_sel_oob;
  logic                   r_s_tready, w_s_tready_next;
  logic                   r_tready_int;
  logic                   w_in_xfer, w_in_valid, w_early, w_out_drain;
  logic [M_COUNT-1:0]     w_in_onehot;
  logic [M_COUNT-1:0]     r_out_valid, w_out_valid_next;
  logic [M_COUNT-1:0]     r_tmp_valid, w_tmp_valid_next;
  logic                   w_store_in_out, w_store_in_tmp, w_store_tmp_out;

  logic [DATA_WIDTH-1:0]  r_out_data, r_tmp_data;
  logic [KEEP_WIDTH-1:0]  r_out_keep, r_tmp_keep;
  logic                   r_out_last, r_tmp_last;
  logic [ID_WIDTH-1:0]    r_out_id, r_tmp_id;
  logic [DEST_WIDTH-1:0]  r_out_dest, r_tmp_dest;
  logic [USER_WIDTH-1:0]  r_out_user, r_tmp_user;

  // r_run keeps header ready low while reset is asserted
  assign w_hdr_ready  = r_run && enable && (r_state == ST_IDLE) && !(|r_hdr_valid);
  assign w_hdr_accept = bus.s_udp_hdr_valid && w_hdr_ready;
  assign w_sel_oob    = (int'(select) >= M_COUNT);

  assign w_in_xfer  = bus.s_udp_payload_axis_tvalid && r_s_tready;
  assign w_in_valid = w_in_xfer && !r_drop;

  // skid may accept next cycle if the output drains now, or both stages stay clear
  assign w_out_drain = |(r_out_valid & bus.m_udp_payload_axis_tready);
  assign w_early     = w_out_drain || (!(|r_tmp_valid) && (!(|r_out_valid) || !w_in_valid));

  // lane of the incoming beat as a one-hot valid vector
  always_comb begin
    w_in_onehot = '0;
    if (w_in_valid) w_in_onehot[r_sel] = 1'b1;
  end

  // frame FSM: header accept, header valid per lane, registered input tready
  always_comb begin
    w_state_next     = r_state;
    w_drop_next      = r_drop;
    w_sel_next       = r_sel;
    w_hdr_valid_next = r_hdr_valid & ~bus.m_udp_hdr_ready;
    w_hdr_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hdr_accept) begin
          w_state_next = ST_ACTIVE;
          w_sel_next   = select;
          w_drop_next  = drop || w_sel_oob;
          if (!(drop || w_sel_oob)) begin
            w_hdr_load              = 1'b1;
            w_hdr_valid_next[select] = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (w_in_xfer && bus.s_udp_payload_axis_tlast) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_s_tready_next = (w_state_next == ST_ACTIVE) && (w_drop_next || w_early);
  end

  // skid buffer control: out register fed from input or temp, temp catches stalls
  always_comb begin
    w_out_valid_next = r_out_valid;
    w_tmp_valid_next = r_tmp_valid;
    w_store_in_out   = 1'b0;
    w_store_in_tmp   = 1'b0;
    w_store_tmp_out  = 1'b0;
    if (r_tready_int) begin
      if (w_out_drain || !(|r_out_valid)) begin
        w_out_valid_next = w_in_onehot;
        w_store_in_out   = 1'b1;
      end else begin
        w_tmp_valid_next = w_in_onehot;
        w_store_in_tmp   = 1'b1;
      end
    end else if (w_out_drain) begin
      w_out_valid_next = r_tmp_valid;
      w_tmp_valid_next = '0;
      w_store_tmp_out  = 1'b1;
    end
  end

  // control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_drop       <= 1'b0;
      r_sel        <= '0;
      r_run        <= 1'b0;
      r_hdr_valid  <= '0;
      r_s_tready   <= 1'b0;
      r_tready_int <= 1'b0;
      r_out_valid  <= '0;
      r_tmp_valid  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_drop       <= w_drop_next;
      r_sel        <= w_sel_next;
      r_run        <= 1'b1;
      r_hdr_valid  <= w_hdr_valid_next;
      r_s_tready   <= w_s_tready_next;
      r_tready_int <= w_early;
      r_out_valid  <= w_out_valid_next;
      r_tmp_valid  <= w_tmp_valid_next;
    end
  end

  // header and payload data registers (no reset needed)
  always_ff @(posedge clk) begin
    if (w_hdr_load) r_hdr <= bus.s_udp_hdr;
    if (w_store_in_out) begin
      r_out_data <= bus.s_udp_payload_axis_tdata;
      r_out_keep <= bus.s_udp_payload_axis_tkeep;
      r_out_last <= bus.s_udp_payload_axis_tlast;
      r_out_id   <= bus.s_udp_payload_axis_tid;
      r_out_dest <= bus.s_udp_payload_axis_tdest;
      r_out_user <= bus.s_udp_payload_axis_tuser;
    end else if (w_store_tmp_out) begin
      r_out_data <= r_tmp_data;
      r_out_keep <= r_tmp_keep;
      r_out_last <= r_tmp_last;
      r_out_id   <= r_tmp_id;
      r_out_dest <= r_tmp_dest;
      r_out_user <= r_tmp_user;
    end
    if (w_store_in_tmp) begin
      r_tmp_data <= bus.s_udp_payload_axis_tdata;
      r_tmp_keep <= bus.s_udp_payload_axis_tkeep;
      r_tmp_last <= bus.s_udp_payload_axis_tlast;
      r_tmp_id   <= bus.s_udp_payload_axis_tid;
      r_tmp_dest <= bus.s_udp_payload_axis_tdest;
      r_tmp_user <= bus.s_udp_payload_axis_tuser;
    end
  end

  assign bus.s_udp_hdr_ready           = w_hdr_ready;
  assign bus.s_udp_payload_axis_tready = r_s_tready;

  assign bus.m_udp_hdr_valid           = r_hdr_valid;
  assign bus.m_udp_hdr                 = {M_COUNT{r_hdr}};
  assign bus.m_udp_payload_axis_tvalid = r_out_valid;
  assign bus.m_udp_payload_axis_tdata  = {M_COUNT{r_out_data}};
  assign bus.m_udp_payload_axis_tlast  = {M_COUNT{r_out_last}};
  assign bus.m_udp_payload_axis_tkeep  = KEEP_ENABLE ? {M_COUNT{r_out_keep}} : '1;
  assign bus.m_udp_payload_axis_tid    = ID_ENABLE   ? {M_COUNT{r_out_id}}   : '0;
  assign bus.m_udp_payload_axis_tdest  = DEST_ENABLE ? {M_COUNT{r_out_dest}} : '0;
  assign bus.m_udp_payload_axis_tuser  = USER_ENABLE ? {M_COUNT{r_out_user}} : '0;

endmodule

// File: tb/tb_udp_demux.sv
// Scoreboard bench for udp_demux: frames are generated with random content,
// expected per-lane headers/beats are queued at header accept, and a monitor
// pops and compares every output transfer.
module tb_udp_demux;
  localparam int M   = 4;
  localparam int HW  = 336;
  localparam int DW  = 64;
  localparam int KW  = 8;

  typedef struct packed {
    logic [HW-1:0]        hdr;
    logic [1:0]           sel;
    logic                 drop;
    logic [3:0]           len;
    logic [7:0][DW-1:0]   data;
    logic [7:0][KW-1:0]   keep;
    logic [7:0]           user;
  } frame_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       drop;
  logic [1:0] select;

  udp_demux_if #(.M_COUNT(M), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(8),
                 .DEST_WIDTH(8), .USER_WIDTH(1)) bus ();

  udp_demux #(.M_COUNT(M), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_ENABLE(1'b0),
              .DEST_ENABLE(1'b0), .USER_ENABLE(1'b1), .USER_WIDTH(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .enable (enable),
    .drop   (drop),
    .select (select)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [HW-1:0] exp_hdr  [M][$];
  beat_t         exp_beat [M][$];
  frame_t        pend[$];
  frame_t        active[$];
  int            hdr_acc   = 0;
  int            last_done = 0;

  int         rdy_mode = 0;
  bit         gap_en   = 1'b0;
  logic [3:0] pat      = 4'b1001;
  logic [1:0] pat_idx  = 2'd0;

  // sink readiness: all-ones, random, or lane-0 pattern 1,0,0,1
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: begin
        bus.m_udp_hdr_ready           = '1;
        bus.m_udp_payload_axis_tready = '1;
      end
      1: begin
        bus.m_udp_hdr_ready           = 4'($urandom);
        bus.m_udp_payload_axis_tready = 4'($urandom);
      end
      default: begin
        bus.m_udp_hdr_ready           = '1;
        bus.m_udp_payload_axis_tready = {3'b111, pat[pat_idx]};
        pat_idx = pat_idx + 2'd1;
      end
    endcase
  end

  // monitor: every output transfer must match the head of its lane's queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (|bus.m_udp_hdr_valid || |bus.m_udp_payload_axis_tvalid) begin
        checks++;
        if ($countones(bus.m_udp_hdr_valid) > 1 || $countones(bus.m_udp_payload_axis_tvalid) > 1) begin
          errors++;
          $display("FAIL onehot hdr_valid=%b tvalid=%b required at most one bit each",
                   bus.m_udp_hdr_valid, bus.m_udp_payload_axis_tvalid);
        end
      end
      for (int l = 0; l < M; l++) begin
        if (bus.m_udp_hdr_valid[l] && bus.m_udp_hdr_ready[l]) begin
          checks++;
          if (exp_hdr[l].size() == 0) begin
            errors++;
            $display("FAIL hdr_unexpected lane %0d got header, required none", l);
          end else begin
            logic [HW-1:0] e;
            e = exp_hdr[l].pop_front();
            if (bus.m_udp_hdr[l*HW +: HW] != e) begin
              errors++;
              $display("FAIL hdr_data lane %0d got %h required %h", l, bus.m_udp_hdr[l*HW +: HW], e);
            end
          end
        end
        if (bus.m_udp_payload_axis_tvalid[l] && bus.m_udp_payload_axis_tready[l]) begin
          beat_t g;
          g.data = bus.m_udp_payload_axis_tdata[l*DW +: DW];
          g.keep = bus.m_udp_payload_axis_tkeep[l*KW +: KW];
          g.last = bus.m_udp_payload_axis_tlast[l];
          g.user = bus.m_udp_payload_axis_tuser[l];
          checks++;
          if (exp_beat[l].size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected lane %0d got %h, required none", l, g);
          end else begin
            beat_t e;
            e = exp_beat[l].pop_front();
            if (g != e) begin
              errors++;
              $display("FAIL beat_data lane %0d got %h required %h", l, g, e);
            end
          end
          checks++;
          if (bus.m_udp_payload_axis_tid[l*8 +: 8] != 8'd0 || bus.m_udp_payload_axis_tdest[l*8 +: 8] != 8'd0) begin
            errors++;
            $display("FAIL sideband_zero lane %0d got tid=%h tdest=%h required 00",
                     l, bus.m_udp_payload_axis_tid[l*8 +: 8], bus.m_udp_payload_axis_tdest[l*8 +: 8]);
          end
        end
      end
    end
  end

  function automatic frame_t mk_frame(input logic [1:0] sel, input logic drp, input int unsigned len);
    frame_t f;
    for (int i = 0; i < 10; i++) f.hdr[i*32 +: 32] = $urandom;
    f.hdr[335:320] = 16'($urandom);
    f.sel  = sel;
    f.drop = drp;
    f.len  = 4'(len);
    for (int i = 0; i < 8; i++) begin
      f.data[i] = {$urandom, $urandom};
      f.keep[i] = 8'($urandom);
      f.user[i] = 1'($urandom);
    end
    return f;
  endfunction

  function automatic bit queues_empty();
    for (int l = 0; l < M; l++)
      if (exp_hdr[l].size() != 0 || exp_beat[l].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // present a header (called at posedge+1); on accept, queue the frame's expected output
  task automatic send_hdr(input frame_t f);
    int unsigned w = 0;
    bus.s_udp_hdr       = f.hdr;
    select              = f.sel;
    drop                = f.drop;
    bus.s_udp_hdr_valid = 1'b1;
    @(negedge clk);
    while (!bus.s_udp_hdr_ready && w < 2000) begin
      w++;
      @(negedge clk);
    end
    checks++;
    if (!bus.s_udp_hdr_ready) begin
      errors++;
      $display("FAIL hdr_timeout s_udp_hdr_ready stayed 0, required 1");
    end else begin
      if (last_done != hdr_acc) begin
        errors++;
        $display("FAIL hdr_order header accepted with %0d frames ended, required %0d", last_done, hdr_acc);
      end
      hdr_acc++;
      if (!f.drop) begin
        exp_hdr[f.sel].push_back(f.hdr);
        for (int i = 0; i < int'(f.len); i++) begin
          beat_t b;
          b.data = f.data[i];
          b.keep = f.keep[i];
          b.last = (i == int'(f.len) - 1);
          b.user = f.user[i];
          exp_beat[f.sel].push_back(b);
        end
      end
      active.push_back(f);
    end
    @(posedge clk);
    #1;
    bus.s_udp_hdr_valid = 1'b0;
    select = 2'($urandom);
    drop   = 1'($urandom);
  endtask

  // present beat i of frame f (called at posedge+1)
  task automatic send_beat(input frame_t f, input int i);
    int unsigned w = 0;
    bus.s_udp_payload_axis_tdata  = f.data[i];
    bus.s_udp_payload_axis_tkeep  = f.keep[i];
    bus.s_udp_payload_axis_tuser  = f.user[i];
    bus.s_udp_payload_axis_tlast  = (i == int'(f.len) - 1);
    bus.s_udp_payload_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_udp_payload_axis_tready && w < 2000) begin
      w++;
      @(negedge clk);
    end
    if (!bus.s_udp_payload_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout s tready stayed 0, required 1");
    end else begin
      if (f.drop) begin
        checks++;
        if (w != 0) begin
          errors++;
          $display("FAIL drop_ready dropped beat waited %0d cycles, required 0", w);
        end
      end
      if (i == int'(f.len) - 1) last_done++;
    end
    @(posedge clk);
    #1;
    bus.s_udp_payload_axis_tvalid = 1'b0;
  endtask

  task automatic hdr_proc(input int n);
    for (int k = 0; k < n; k++) begin
      frame_t f;
      f = pend.pop_front();
      if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_hdr(f);
    end
  endtask

  task automatic payload_proc(input int n);
    for (int k = 0; k < n; k++) begin
      frame_t f;
      int unsigned w = 0;
      while (active.size() == 0 && w < 5000) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (active.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout no accepted header for frame %0d, required one", k);
        return;
      end
      f = active.pop_front();
      for (int i = 0; i < int'(f.len); i++) begin
        if (gap_en && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        send_beat(f, i);
      end
    end
  endtask

  task automatic run_batch(input int n);
    int unsigned w = 0;
    fork
      hdr_proc(n);
      payload_proc(n);
    join
    while (!queues_empty() && w < 3000) begin
      @(posedge clk);
      w++;
    end
    checks++;
    if (!queues_empty()) begin
      errors++;
      $display("FAIL drain expected output still pending after %0d cycles, required none", w);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    rst_n  = 1'b0;
    enable = 1'b1;
    drop   = 1'b0;
    select = 2'd0;
    bus.s_udp_hdr_valid           = 1'b0;
    bus.s_udp_hdr                 = '0;
    bus.s_udp_payload_axis_tvalid = 1'b0;
    bus.s_udp_payload_axis_tdata  = '0;
    bus.s_udp_payload_axis_tkeep  = '0;
    bus.s_udp_payload_axis_tlast  = 1'b0;
    bus.s_udp_payload_axis_tid    = '0;
    bus.s_udp_payload_axis_tdest  = '0;
    bus.s_udp_payload_axis_tuser  = '0;
    bus.m_udp_hdr_ready           = '1;
    bus.m_udp_payload_axis_tready = '1;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.s_udp_hdr_ready !== 1'b0) begin errors++; $display("FAIL rst_hdr_ready got %b required 0", bus.s_udp_hdr_ready); end
    checks++;
    if (bus.s_udp_payload_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b required 0", bus.s_udp_payload_axis_tready); end
    checks++;
    if (bus.m_udp_hdr_valid !== 4'b0) begin errors++; $display("FAIL rst_hdr_valid got %b required 0000", bus.m_udp_hdr_valid); end
    checks++;
    if (bus.m_udp_payload_axis_tvalid !== 4'b0) begin errors++; $display("FAIL rst_tvalid got %b required 0000", bus.m_udp_payload_axis_tvalid); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3-beat frame to lane 2
    f = mk_frame(2'd2, 1'b0, 3);
    f.data[0] = {8{8'h01}};
    f.data[1] = {8{8'h02}};
    f.data[2] = {8{8'h03}};
    pend.push_back(f);
    run_batch(1);

    // back-to-back frames to lanes 1 and 3
    pend.push_back(mk_frame(2'd1, 1'b0, 4));
    pend.push_back(mk_frame(2'd3, 1'b0, 4));
    run_batch(2);

    // dropped 4-beat frame, then a normal frame
    pend.push_back(mk_frame(2'd0, 1'b1, 4));
    pend.push_back(mk_frame(2'd3, 1'b0, 2));
    run_batch(2);

    // lane 0 stalling 1,0,0,1 during an 8-beat frame
    rdy_mode = 2;
    pend.push_back(mk_frame(2'd0, 1'b0, 8));
    run_batch(1);
    rdy_mode = 0;

    // enable low holds off a pending header
    enable = 1'b0;
    pend.push_back(mk_frame(2'd1, 1'b0, 2));
    fork
      run_batch(1);
      begin
        repeat (20) begin
          @(negedge clk);
          checks++;
          if (bus.s_udp_hdr_ready !== 1'b0) begin
            errors++;
            $display("FAIL enable_low hdr_ready got %b required 0", bus.s_udp_hdr_ready);
          end
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_udp_hdr_ready !== 1'b1) begin
          errors++;
          $display("FAIL enable_rise hdr_ready got %b required 1", bus.s_udp_hdr_ready);
        end
      end
    join

    // reset during beat 2 of a 5-beat frame
    f = mk_frame(2'd1, 1'b0, 5);
    send_hdr(f);
    void'(active.pop_front());
    send_beat(f, 0);
    bus.s_udp_payload_axis_tdata  = f.data[1];
    bus.s_udp_payload_axis_tlast  = 1'b0;
    bus.s_udp_payload_axis_tvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.m_udp_hdr_valid !== 4'b0 || bus.m_udp_payload_axis_tvalid !== 4'b0) begin
      errors++;
      $display("FAIL midrst_valids got hdr=%b tvalid=%b required 0000", bus.m_udp_hdr_valid, bus.m_udp_payload_axis_tvalid);
    end
    checks++;
    if (bus.s_udp_hdr_ready !== 1'b0 || bus.s_udp_payload_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready got hdr_ready=%b tready=%b required 0", bus.s_udp_hdr_ready, bus.s_udp_payload_axis_tready);
    end
    bus.s_udp_payload_axis_tvalid = 1'b0;
    for (int l = 0; l < M; l++) begin
      exp_hdr[l].delete();
      exp_beat[l].delete();
    end
    hdr_acc   = 0;
    last_done = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pend.push_back(mk_frame(2'd0, 1'b0, 3));
    run_batch(1);

    // randomized traffic with random stalls and input gaps
    rdy_mode = 1;
    gap_en   = 1'b1;
    for (int k = 0; k < 40; k++)
      pend.push_back(mk_frame(2'($urandom), ($urandom_range(0, 4) == 0), $urandom_range(1, 8)));
    run_batch(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
